// File: rtl/overlap_trim_unit_pkg.sv
// Shared types and helpers for the overlap/trim stacking unit.
package overlap_trim_unit_pkg;

    // Widest coordinate the helpers handle; instances must keep XW at or below this.
    localparam int COORD_W_MAX = 16;

    typedef logic [COORD_W_MAX-1:0] coord_t;

    // Unit control states; IDLE is the only state that accepts a block.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        TRIM = 3'd2,
        RESP = 3'd3,
        DONE = 3'd4
    } state_e;

    function automatic coord_t coord_max(input coord_t a, input coord_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic coord_t coord_min(input coord_t a, input coord_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_t coord_absdiff(input coord_t a, input coord_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/overlap_trim_unit_if.sv
// Request/response bus between the block dropper and the trim unit.
interface overlap_trim_unit_if #(
    parameter int XW = 9,
    parameter int SW = 4,
    parameter int LW = 4
) ();

    logic          req_valid;
    logic          req_ready;
    logic [XW-1:0] curr_start;
    logic [XW-1:0] curr_end;

    logic          resp_valid;
    logic          resp_ready;
    logic [XW-1:0] new_start;
    logic [XW-1:0] new_end;
    logic [SW-1:0] new_size;
    logic          hit;
    logic          perfect;
    logic          game_over;
    logic          win;
    logic [LW-1:0] level;

    // Side that drops blocks and consumes results.
    modport master (
        output req_valid, curr_start, curr_end, resp_ready,
        input  req_ready, resp_valid, new_start, new_end, new_size,
               hit, perfect, game_over, win, level
    );

    // The trim unit itself.
    modport slave (
        input  req_valid, curr_start, curr_end, resp_ready,
        output req_ready, resp_valid, new_start, new_end, new_size,
               hit, perfect, game_over, win, level
    );

endinterface

// File: rtl/overlap_trim_unit_interval_overlap.sv
// Combinational comparison of the dropped interval (a) against the stack top (b).
module interval_overlap
    import overlap_trim_unit_pkg::*;
#(
    parameter int XW  = 9,
    parameter int TOL = 0
) (
    input  logic [XW-1:0] a_start_i,
    input  logic [XW-1:0] a_end_i,
    input  logic [XW-1:0] b_start_i,
    input  logic [XW-1:0] b_end_i,
    input  logic          b_valid_i,
    output logic [XW-1:0] lo_o,
    output logic [XW-1:0] hi_o,
    output logic          hit_o,
    output logic          perfect_o
);

    coord_t a_s, a_e, b_s, b_e;
    logic   well_formed;
    logic   overlap;

    assign a_s = coord_t'(a_start_i);
    assign a_e = coord_t'(a_end_i);
    assign b_s = coord_t'(b_start_i);
    assign b_e = coord_t'(b_end_i);

    assign lo_o = XW'(coord_max(a_s, b_s));
    assign hi_o = XW'(coord_min(a_e, b_e));

    // Inclusive bounds: blocks that merely touch at one column still overlap.
    assign well_formed = (a_s <= a_e);
    assign overlap     = (a_s <= b_e) && (a_e >= b_s);

    // With no stack top yet, any well-formed block lands.
    assign hit_o     = well_formed && (!b_valid_i || overlap);
    assign perfect_o = hit_o && b_valid_i
                     && (coord_absdiff(a_s, b_s) <= coord_t'(TOL))
                     && (coord_absdiff(a_e, b_e) <= coord_t'(TOL));

endmodule

// File: rtl/overlap_trim_unit.sv
// Stacking-game trim unit: accepts a dropped block, trims it against the
// previous block, reports the result and tracks level / terminal flags.
module overlap_trim_unit
    import overlap_trim_unit_pkg::*;
#(
    parameter int XW     = 9,
    parameter int SW     = 4,
    parameter int LEVELS = 12,
    parameter int TOL    = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    overlap_trim_unit_if.slave bus
);

    localparam int            LW       = $clog2(LEVELS + 1);
    localparam logic [XW:0]   SIZE_MAX = (XW + 1)'((1 << SW) - 1);

    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic [XW-1:0] cs_q, cs_d, ce_q, ce_d;
    logic [XW-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [XW-1:0] ps_q, ps_d, pe_q, pe_d;
    logic          pv_q, pv_d;
    logic [XW-1:0] ns_q, ns_d, ne_q, ne_d;
    logic [SW-1:0] size_q, size_d;
    logic          hit_q, hit_d, perf_q, perf_d;
    logic          go_q, go_d, win_q, win_d;
    logic [LW-1:0] lvl_q, lvl_d;

    logic          req_ready;
    logic [XW-1:0] ov_lo, ov_hi;
    logic          ov_hit, ov_perfect;
    logic [XW-1:0] trim_start, trim_end;
    logic [XW:0]   span;
    logic [SW-1:0] trim_size;

    interval_overlap #(
        .XW  (XW),
        .TOL (TOL)
    ) u_overlap (
        .a_start_i (cs_q),
        .a_end_i   (ce_q),
        .b_start_i (ps_q),
        .b_end_i   (pe_q),
        .b_valid_i (pv_q),
        .lo_o      (ov_lo),
        .hi_o      (ov_hi),
        .hit_o     (ov_hit),
        .perfect_o (ov_perfect)
    );

    // ready_q holds off acceptance for one cycle after reset or clear.
    assign req_ready      = ready_q && (state_q == IDLE);
    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.new_start  = ns_q;
    assign bus.new_end    = ne_q;
    assign bus.new_size   = size_q;
    assign bus.hit        = hit_q;
    assign bus.perfect    = perf_q;
    assign bus.game_over  = go_q;
    assign bus.win        = win_q;
    assign bus.level      = lvl_q;

    // Trimmed bounds and saturated width for a landing block.
    always_comb begin
        trim_start = lo_q;
        trim_end   = hi_q;
        if (!pv_q) begin
            trim_start = cs_q;
            trim_end   = ce_q;
        end else if (ov_perfect) begin
            trim_start = ps_q;
            trim_end   = pe_q;
        end
        span      = {1'b0, trim_end} - {1'b0, trim_start} + (XW + 1)'(1);
        trim_size = (span > SIZE_MAX) ? SW'(SIZE_MAX) : SW'(span);
    end

    // Next-state and datapath updates; clear overrides everything like a reset.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b1;
        cs_d    = cs_q;
        ce_d    = ce_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        ps_d    = ps_q;
        pe_d    = pe_q;
        pv_d    = pv_q;
        ns_d    = ns_q;
        ne_d    = ne_q;
        size_d  = size_q;
        hit_d   = hit_q;
        perf_d  = perf_q;
        go_d    = go_q;
        win_d   = win_q;
        lvl_d   = lvl_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready) begin
                    cs_d    = bus.curr_start;
                    ce_d    = bus.curr_end;
                    state_d = CALC;
                end
            end
            CALC: begin
                lo_d    = ov_lo;
                hi_d    = ov_hi;
                state_d = TRIM;
            end
            TRIM: begin
                hit_d  = ov_hit;
                perf_d = ov_perfect;
                if (ov_hit) begin
                    ns_d   = trim_start;
                    ne_d   = trim_end;
                    size_d = trim_size;
                    ps_d   = trim_start;
                    pe_d   = trim_end;
                    pv_d   = 1'b1;
                    lvl_d  = lvl_q + LW'(1);
                    if ((lvl_q + LW'(1)) == LW'(LEVELS)) begin
                        win_d = 1'b1;
                    end
                end else begin
                    ns_d   = '0;
                    ne_d   = '0;
                    size_d = '0;
                    go_d   = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = (go_q || win_q) ? DONE : IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            state_d = IDLE;
            ready_d = 1'b0;
            cs_d    = '0;
            ce_d    = '0;
            lo_d    = '0;
            hi_d    = '0;
            ps_d    = '0;
            pe_d    = '0;
            pv_d    = 1'b0;
            ns_d    = '0;
            ne_d    = '0;
            size_d  = '0;
            hit_d   = 1'b0;
            perf_d  = 1'b0;
            go_d    = 1'b0;
            win_d   = 1'b0;
            lvl_d   = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            cs_q    <= '0;
            ce_q    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            ps_q    <= '0;
            pe_q    <= '0;
            pv_q    <= 1'b0;
            ns_q    <= '0;
            ne_q    <= '0;
            size_q  <= '0;
            hit_q   <= 1'b0;
            perf_q  <= 1'b0;
            go_q    <= 1'b0;
            win_q   <= 1'b0;
            lvl_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cs_q    <= cs_d;
            ce_q    <= ce_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ps_q    <= ps_d;
            pe_q    <= pe_d;
            pv_q    <= pv_d;
            ns_q    <= ns_d;
            ne_q    <= ne_d;
            size_q  <= size_d;
            hit_q   <= hit_d;
            perf_q  <= perf_d;
            go_q    <= go_d;
            win_q   <= win_d;
            lvl_q   <= lvl_d;
        end
    end

endmodule

// File: tb/tb_overlap_trim_unit.sv
// Directed bench for overlap_trim_unit (XW=9, SW=4, LEVELS=3, TOL=1).
module tb_overlap_trim_unit;

    localparam int XW     = 9;
    localparam int SW     = 4;
    localparam int LEVELS = 3;
    localparam int TOL    = 1;
    localparam int LW     = 2;

    logic clk = 1'b0;
    logic resetn;
    logic clear;

    always #5 clk = ~clk;

    overlap_trim_unit_if #(.XW(XW), .SW(SW), .LW(LW)) bus ();

    overlap_trim_unit #(
        .XW     (XW),
        .SW     (SW),
        .LEVELS (LEVELS),
        .TOL    (TOL)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .clear  (clear),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int clr;
        int cs;
        int ce;
        int hit;
        int perf;
        int ns;
        int ne;
        int size;
        int lvl;
        int go;
        int win;
        int rdy;
    } vec_t;

    vec_t vec [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    // Waits (bounded) for req_ready, then presents one block for a single edge.
    task automatic accept_req(input int s, input int e);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.curr_start = XW'(s);
        bus.curr_end   = XW'(e);
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.curr_start = 9'h1AB;
        bus.curr_end   = 9'h0F5;
    endtask

    // lat counts clock edges from the accept edge (=1) to resp_valid visible.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_resp();
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;

        resetn         = 1'b0;
        clear          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.curr_start = '0;
        bus.curr_end   = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_hit", 32'(bus.hit), 32'd0);
        chk("rst_size", 32'(bus.new_size), 32'd0);
        chk("rst_game_over", 32'(bus.game_over), 32'd0);
        chk("rst_win", 32'(bus.win), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("rel_req_ready", 32'(bus.req_ready), 32'd1);

        //        clr  cs   ce  hit prf  ns   ne  sz lvl go win rdy
        vec[0]  = '{0,  40,  79, 1, 0,  40,  79, 15, 1, 0, 0, 1};
        vec[1]  = '{0,  60,  99, 1, 0,  60,  79, 15, 2, 0, 0, 1};
        vec[2]  = '{0,   0,  10, 0, 0,   0,   0,  0, 2, 1, 0, 0};
        vec[3]  = '{1,  10,  13, 1, 0,  10,  13,  4, 1, 0, 0, 1};
        vec[4]  = '{0,  11,  14, 1, 1,  10,  13,  4, 2, 0, 0, 1};
        vec[5]  = '{1,  10,  13, 1, 0,  10,  13,  4, 1, 0, 0, 1};
        vec[6]  = '{0,  13,  16, 1, 0,  13,  13,  1, 2, 0, 0, 1};
        vec[7]  = '{0,  13,  13, 1, 1,  13,  13,  1, 3, 0, 1, 0};
        vec[8]  = '{1,   5,   2, 0, 0,   0,   0,  0, 0, 1, 0, 0};
        vec[9]  = '{1,   0, 511, 1, 0,   0, 511, 15, 1, 0, 0, 1};
        vec[10] = '{0, 511, 511, 1, 0, 511, 511,  1, 2, 0, 0, 1};
        vec[11] = '{0,   0, 510, 0, 0,   0,   0,  0, 2, 1, 0, 0};
        vec[12] = '{1,  10,  13, 1, 0,  10,  13,  4, 1, 0, 0, 1};
        vec[13] = '{0,  12,  13, 1, 0,  12,  13,  2, 2, 0, 0, 1};
        vec[14] = '{0,  11,  14, 1, 1,  12,  13,  2, 3, 0, 1, 0};
        vec[15] = '{1,  20,  30, 1, 0,  20,  30, 11, 1, 0, 0, 1};
        vec[16] = '{0,   5,  20, 1, 0,  20,  20,  1, 2, 0, 0, 1};
        vec[17] = '{0,  21,  25, 0, 0,   0,   0,  0, 2, 1, 0, 0};

        for (int i = 0; i < 18; i++) begin
            if (vec[i].clr != 0) do_clear();
            accept_req(vec[i].cs, vec[i].ce);
            wait_resp(lat);
            chk("latency", 32'(lat), 32'd3);
            chk("hit", 32'(bus.hit), 32'(vec[i].hit));
            chk("perfect", 32'(bus.perfect), 32'(vec[i].perf));
            chk("new_start", 32'(bus.new_start), 32'(vec[i].ns));
            chk("new_end", 32'(bus.new_end), 32'(vec[i].ne));
            chk("new_size", 32'(bus.new_size), 32'(vec[i].size));
            chk("level", 32'(bus.level), 32'(vec[i].lvl));
            chk("game_over", 32'(bus.game_over), 32'(vec[i].go));
            chk("win", 32'(bus.win), 32'(vec[i].win));
            $display("txn %0d: curr=(%0d,%0d) hit=%0d perfect=%0d new=(%0d,%0d) size=%0d level=%0d go=%0d win=%0d lat=%0d",
                     i, vec[i].cs, vec[i].ce, bus.hit, bus.perfect, bus.new_start, bus.new_end,
                     bus.new_size, bus.level, bus.game_over, bus.win, lat);
            take_resp();
            chk("ready_after", 32'(bus.req_ready), 32'(vec[i].rdy));
            chk("resp_dropped", 32'(bus.resp_valid), 32'd0);
        end

        // Back-pressure: outputs hold while resp_ready stays low.
        do_clear();
        accept_req(20, 30);
        wait_resp(lat);
        chk("stall_latency", 32'(lat), 32'd3);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(bus.resp_valid), 32'd1);
            chk("stall_start", 32'(bus.new_start), 32'd20);
            chk("stall_end", 32'(bus.new_end), 32'd30);
            chk("stall_size", 32'(bus.new_size), 32'd11);
            chk("stall_level", 32'(bus.level), 32'd1);
        end
        $display("txn stall: curr=(20,30) held 5 cycles new=(%0d,%0d)", bus.new_start, bus.new_end);
        take_resp();

        // Clear while a response is pending: it vanishes and the stack restarts.
        accept_req(25, 35);
        wait_resp(lat);
        chk("pre_clear_start", 32'(bus.new_start), 32'd25);
        chk("pre_clear_end", 32'(bus.new_end), 32'd30);
        chk("pre_clear_level", 32'(bus.level), 32'd2);
        do_clear();
        chk("clr_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("clr_level", 32'(bus.level), 32'd0);
        chk("clr_hit", 32'(bus.hit), 32'd0);
        chk("clr_size", 32'(bus.new_size), 32'd0);
        chk("clr_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("clr_req_ready_next", 32'(bus.req_ready), 32'd1);
        $display("txn clear_in_resp: level=%0d resp_valid=%0d", bus.level, bus.resp_valid);

        accept_req(100, 104);
        wait_resp(lat);
        chk("first_after_clear_hit", 32'(bus.hit), 32'd1);
        chk("first_after_clear_perfect", 32'(bus.perfect), 32'd0);
        chk("first_after_clear_start", 32'(bus.new_start), 32'd100);
        chk("first_after_clear_end", 32'(bus.new_end), 32'd104);
        chk("first_after_clear_size", 32'(bus.new_size), 32'd5);
        chk("first_after_clear_level", 32'(bus.level), 32'd1);
        $display("txn after_clear: curr=(100,104) hit=%0d new=(%0d,%0d) level=%0d",
                 bus.hit, bus.new_start, bus.new_end, bus.level);
        take_resp();

        // Within tolerance on both edges: snaps back to the previous bounds.
        accept_req(101, 103);
        wait_resp(lat);
        chk("tol_perfect", 32'(bus.perfect), 32'd1);
        chk("tol_start", 32'(bus.new_start), 32'd100);
        chk("tol_end", 32'(bus.new_end), 32'd104);
        chk("tol_level", 32'(bus.level), 32'd2);
        $display("txn tol: curr=(101,103) perfect=%0d new=(%0d,%0d)", bus.perfect, bus.new_start, bus.new_end);
        take_resp();

        accept_req(100, 104);
        wait_resp(lat);
        chk("win_flag", 32'(bus.win), 32'd1);
        chk("win_level", 32'(bus.level), 32'd3);
        $display("txn win: curr=(100,104) level=%0d win=%0d", bus.level, bus.win);
        take_resp();

        // DONE ignores further requests and holds flags.
        bus.req_valid  = 1'b1;
        bus.curr_start = 9'd100;
        bus.curr_end   = 9'd104;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("done_req_ready", 32'(bus.req_ready), 32'd0);
            chk("done_resp_valid", 32'(bus.resp_valid), 32'd0);
        end
        bus.req_valid = 1'b0;
        chk("done_level", 32'(bus.level), 32'd3);
        chk("done_win", 32'(bus.win), 32'd1);
        $display("txn done_ignore: level=%0d win=%0d", bus.level, bus.win);

        // Reset in the middle of a response handshake wins.
        do_clear();
        accept_req(50, 60);
        wait_resp(lat);
        chk("pre_rst_valid", 32'(bus.resp_valid), 32'd1);
        resetn         = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("midrst_level", 32'(bus.level), 32'd0);
        chk("midrst_hit", 32'(bus.hit), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        resetn         = 1'b1;
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        chk("midrst_req_ready_next", 32'(bus.req_ready), 32'd1);
        accept_req(0, 3);
        wait_resp(lat);
        chk("post_rst_hit", 32'(bus.hit), 32'd1);
        chk("post_rst_start", 32'(bus.new_start), 32'd0);
        chk("post_rst_end", 32'(bus.new_end), 32'd3);
        chk("post_rst_size", 32'(bus.new_size), 32'd4);
        chk("post_rst_level", 32'(bus.level), 32'd1);
        $display("txn after_reset: curr=(0,3) hit=%0d new=(%0d,%0d) level=%0d",
                 bus.hit, bus.new_start, bus.new_end, bus.level);
        take_resp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/overlap_trim_unit.md
OVERLAP_TRIM_UNIT -- requirements
Module: overlap_trim_unit

Interface
REQ-001 Parameter XW, default 9, coordinate width in pixels/columns.
REQ-002 Parameter SW, default 4, block size width.
REQ-003 Parameter LEVELS, default 12, stack height that wins the game.
REQ-004 Parameter TOL, default 0, perfect-placement tolerance in columns.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 clear  in  1  new-game pulse.
REQ-008 req_valid  in  1  dropped block presented.
REQ-009 req_ready  out  1  unit can accept a block.
REQ-010 curr_start / curr_end  in  XW each  dropped block inclusive column bounds.
REQ-011 resp_valid  out  1  result available.
REQ-012 resp_ready  in  1  consumer accepts result.
REQ-013 new_start / new_end  out  XW each  trimmed block bounds.
REQ-014 new_size  out  SW  trimmed block width.
REQ-015 hit / perfect  out  1 each  overlap found / placement within TOL.
REQ-016 game_over / win  out  1 each  sticky terminal flags.
REQ-017 level  out  $clog2(LEVELS+1)  blocks successfully stacked.

Function
REQ-018 FSM states IDLE, CALC, TRIM, RESP, DONE; IDLE is the only state with req_ready=1.
REQ-019 IDLE->CALC on req_valid&req_ready; the unit registers curr_start/curr_end.
REQ-020 CALC: lo=max(curr_start,prev_start), hi=min(curr_end,prev_end), both registered; ->TRIM.
REQ-021 TRIM: computes hit, perfect, new_* and registers them; ->RESP; resp_valid=1 exactly 3 cycles after the accept edge.
REQ-022 RESP: holds all outputs stable while resp_valid&!resp_ready; on resp_ready goes to IDLE, or to DONE if game_over or win is set.
REQ-023 Overlap rule: hit=1 iff curr_start<=prev_end and curr_end>=prev_start (inclusive bounds, touching edges count).
REQ-024 First block after reset/clear (prev_valid=0): hit=1, new=curr, perfect=0.
REQ-025 perfect=1 iff hit, prev_valid, |curr_start-prev_start|<=TOL and |curr_end-prev_end|<=TOL; new bounds then snap to prev bounds.
REQ-026 Non-perfect hit: new_start=lo, new_end=hi.
REQ-027 new_size=new_end-new_start+1 computed at XW+1 bits, saturating at 2^SW-1.
REQ-028 Malformed request (curr_start>curr_end): treated as a miss.
REQ-029 Miss: hit=0, new_*=0, game_over set, prev bounds unchanged.
REQ-030 Hit: prev bounds<=new bounds, prev_valid=1, level increments; level reaching LEVELS sets win.
REQ-031 DONE: req_ready=0, resp_valid=0, flags and level held until clear or reset.
REQ-032 clear sampled high in any state: next cycle as reset (REQ-034), in-flight request discarded, no response issued.
REQ-033 req_valid outside IDLE is ignored; request fields need only be stable on the accept edge.

Reset
REQ-034 On resetn=0 at a clock edge: state=IDLE, level=0, prev_valid=0, prev bounds=0, all outputs 0 except req_ready=1 one cycle after release.
REQ-035 Reset overrides clear and any handshake, including mid-RESP.

Structure
REQ-036 A shared package holds the FSM state enum and a max/min/absolute-difference helper on XW bits.
REQ-037 One sub-module, interval_overlap, is natural: combinational lo/hi/hit/perfect from two intervals and TOL; the FSM and registers stay in overlap_trim_unit.

Verification
REQ-038 After reset send (40,79): hit=1, new=(40,79), size saturates 15 with SW=4, level=1, resp_valid 3 cycles after accept.
REQ-039 prev=(40,79), send (60,99): new=(60,79), size 15 (sat), level+1; send (0,10) next: hit=0, game_over=1, state DONE, req_ready=0.
REQ-040 TOL=1, prev=(10,13), send (11,14): perfect=1, new=(10,13), size=4.
REQ-041 Edge touch: prev=(10,13), send (13,16): hit=1, new=(13,13), size=1.
REQ-042 Hold resp_ready=0 for 5 cycles: outputs stable; pulse clear during RESP: no response, level=0, next block treated as first.
REQ-043 LEVELS=3, three successive hits: win=1 on third response, DONE entered, further req_valid ignored.
